hwjsoc_multi_timer: RTL and testbench
=====================================

// Module: hwjsoc_multi_timer
// PURPOSE
//  Multi-channel interval timer for the Avalon-MM peripheral bus.
//  - NUM_CH independent down-counters, each CNT_W bits wide.
//  - Each counter reloads from its own PERIOD register.
//  - Each channel supports one-shot or continuous mode, snapshot reads and a per-channel tick pulse.
//  - Channels can be started or stopped together in the same cycle.
//  - Replaces the single-channel 32-bit timer wherever the SoC needs more than one time base.
// PARAMETERS
//  NUM_CH       4         number of channels, 1..7
//  CNT_W        32        counter/period width in bits, 8..32
//  RESET_PERIOD 99999     reset value of every PERIOD register and counter (truncated to CNT_W)
// PORTS
//  clk        in   1        system clock
//  reset_n    in   1        asynchronous, active-low reset
//  address    in   5        word address: [4:2] = block (0..NUM_CH-1 channel, 7 global), [1:0] = register
//  chipselect in   1        slave select
//  write_n    in   1        active-low write strobe; a write occurs when chipselect=1 and write_n=0
//  writedata  in   32       write data
//  readdata   out  32       registered read data
//  irq        out  1        OR over channels of (TO & ITO)
//  tick_out   out  NUM_CH   one-cycle pulse per channel timeout event
// BEHAVIOUR
//  Clocking and reset
//  - Single clock domain; every register is reset asynchronously by reset_n=0, and reset mid-count
//    takes effect immediately.
//  - Reset values:
//    - readdata=0, irq=0, tick_out=0
//    - all channels stopped, TO=0, CONTROL=0, SNAP=0
//    - PERIOD and counter = RESET_PERIOD
//  Channel register map (reg):
//  - 0 STATUS: read {30'b0, RUN, TO}; any write clears TO.
//  - 1 CONTROL: bit0 ITO, bit1 CONT.
//    - bit2 START and bit3 STOP are write-only strobes.
//    - Reads return {28'b0, 2'b0, CONT, ITO}.
//  - 2 PERIOD: read/write, CNT_W bits, zero-extended on read.
//  - 3 SNAP: a write of any value captures the counter; a read returns the captured value.
//  Global block (address[4:2]=7):
//  - reg0 IRQ_PEND: read-only bitmap of TO&ITO.
//  - reg1 START_MASK: write-only; each set bit starts that channel.
//  - reg2 STOP_MASK: write-only; each set bit stops that channel.
//  - Masked starts and stops take effect on the same edge for all selected channels.
//  Read and decode rules
//  - Read latency 1: readdata is updated on every clock edge from the current address.
//  - Unmapped addresses (channel index >= NUM_CH, global reg3) read 0; writes to them are ignored.
//  - Write-data bits above CNT_W are dropped.
//  Counter, per edge:
//  - If a PERIOD write occurred last cycle: counter <= PERIOD and RUN <= 0.
//  - Else if RUN and counter==0:
//    - counter <= PERIOD
//    - TO <= 1
//    - tick_out[ch] <= 1 for exactly one cycle
//    - RUN <= CONT
//  - Else if RUN: counter <= counter-1.
//  - Result: PERIOD=N gives a timeout every N+1 cycles in continuous mode.
//  - PERIOD=0 in continuous mode gives a timeout every cycle; TO stays 1.
//  - A stopped counter holds its value; START resumes from the held value and does not reload.
//  Priority and simultaneous events
//  - START and STOP in the same write: START wins.
//  - Channel START/STOP and global mask hitting the same channel in the same cycle is impossible
//    (single port).
//  - STATUS-write clear coinciding with a timeout event: the set wins, so TO stays 1 and no event
//    is lost.
//  - SNAP write in the same cycle as a reload captures the pre-edge counter value (0).
//  - PERIOD write while running stops the channel; software must issue START again.
//  irq is combinational from the TO and ITO registers.
// TESTING
//  - Reset: RESET_PERIOD=99999, after reset read ch0 PERIOD -> 99999 (readdata valid 1 cycle later);
//    STATUS=0, irq=0.
//  - Continuous mode: PERIOD=9, CONTROL=0x7.
//    - tick_out[0] pulses every 10 cycles.
//    - TO=1 and irq=1 after the first pulse.
//    - A STATUS write clears irq the next cycle.
//  - One-shot mode: PERIOD=4, CONTROL=0x4.
//    - Exactly one tick after 5 cycles; RUN=0 afterwards.
//    - Counter holds 4 (reloaded); no further ticks.
//  - Synchronised start: PERIOD ch0=3, ch1=7, both CONT.
//    - Write START_MASK=0x3.
//    - Ticks ch0 at t+4, t+8; ch1 at t+8; the two coincide at t+8.
//  - Clear/event collision: issue a STATUS write in the cycle ch0 counter==0 -> TO remains 1.
//    - SNAP mid-count returns the exact counter value.
//    - PERIOD write while running -> RUN=0, counter=new PERIOD.
//  - Mid-operation reset and unmapped addresses:
//    - Assert reset_n while running -> all outputs 0 immediately.
//    - Read address 5'h1F (and channel index >= NUM_CH) -> 0.

Source files
------------

// File: rtl/hwjsoc_multi_timer.sv
// hwjsoc_multi_timer: multi-channel Avalon-MM interval timer with reloading down-counters,
// one-shot/continuous modes, snapshots, tick pulses and synchronised global start/stop.
module hwjsoc_multi_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 99999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] tick_out
);
  localparam logic [CNT_W-1:0] RP = CNT_W'(RESET_PERIOD);
  logic [2:0] blk;
  logic [1:0] rg;
  logic wr, gwr;
  logic [NUM_CH-1:0] to_v, ito_v;
  logic [31:0] rdata [NUM_CH];
  logic [31:0] rd_mux;
  assign blk = address[4:2];
  assign rg  = address[1:0];
  assign wr  = chipselect & ~write_n;
  assign gwr = wr && blk == 3'd7;
  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] period, cnt, snap;
      logic run, to, ito, cont, pend, tick;
      logic sel, start, stop, ev;
      assign sel   = wr && blk == 3'(i);
      assign start = (sel && rg == 2'd1 && writedata[2]) || (gwr && rg == 2'd1 && writedata[i]);
      assign stop  = (sel && rg == 2'd1 && writedata[3]) || (gwr && rg == 2'd2 && writedata[i]);
      assign ev    = !pend && run && cnt == '0;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          period <= RP;
          cnt    <= RP;
          snap   <= '0;
          {run, to, ito, cont, pend, tick} <= '0;
        end else begin
          pend <= sel && rg == 2'd2;
          tick <= ev;
          // a clear coinciding with a timeout loses to the set
          to   <= ev | (to & ~(sel && rg == 2'd0));
          if (sel && rg == 2'd2) period <= writedata[CNT_W-1:0];
          if (sel && rg == 2'd1) {cont, ito} <= writedata[1:0];
          if (sel && rg == 2'd3) snap <= cnt;
          cnt  <= (pend || ev) ? period : run ? cnt - 1'b1 : cnt;
          run  <= pend ? 1'b0 : start ? 1'b1 : stop ? 1'b0 : ev ? cont : run;
        end
      end
      assign to_v[i]     = to;
      assign ito_v[i]    = ito;
      assign tick_out[i] = tick;
      assign rdata[i] = rg == 2'd0 ? {30'b0, run, to} :
                        rg == 2'd1 ? {30'b0, cont, ito} :
                        rg == 2'd2 ? 32'(period) : 32'(snap);
    end
  endgenerate
  always_comb begin
    rd_mux = '0;
    if (blk == 3'd7) rd_mux = rg == 2'd0 ? 32'(to_v & ito_v) : '0;
    else for (int k = 0; k < NUM_CH; k++) if (blk == 3'(k)) rd_mux = rdata[k];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else readdata <= rd_mux;
  end
  assign irq = |(to_v & ito_v);
endmodule

// File: tb/tb_hwjsoc_multi_timer.sv
// tb_hwjsoc_multi_timer: directed and randomized checks of the multi-channel timer against
// closed-form timing expectations (tick every N+1 cycles, counter = N - elapsed mod (N+1)).
module tb_hwjsoc_multi_timer;
  localparam int NC = 4;
  logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
  logic [4:0] address = 0;
  logic [31:0] writedata = 0, readdata, d;
  logic irq;
  logic [NC-1:0] tick_out;
  int n_cmp = 0, n_err = 0, cyc = 0, we = 0, t, c;
  int tq [NC][$];
  int base [NC];
  int per [NC];

  hwjsoc_multi_timer #(.NUM_CH(NC), .CNT_W(32), .RESET_PERIOD(99999)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq), .tick_out(tick_out));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) for (int i = 0; i < NC; i++) if (tick_out[i]) tq[i].push_back(cyc);

  function automatic int exp_cnt(int n, int k);
    return n - (k % (n + 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    @(negedge clk);
    address = a; writedata = v; chipselect = 1; write_n = 0;
    @(posedge clk);
    #1;
    chipselect = 0; write_n = 1;
    we = cyc;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    @(negedge clk);
    address = a;
    @(posedge clk);
    #1 v = readdata;
  endtask

  task automatic mark();
    for (int i = 0; i < NC; i++) base[i] = tq[i].size();
  endtask

  function automatic int first_tick(int ch);
    return tq[ch].size() > base[ch] ? tq[ch][base[ch]] : -1;
  endfunction

  function automatic int last_tick(int ch);
    return tq[ch].size() > base[ch] ? tq[ch][tq[ch].size() - 1] : -1;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readdata", readdata, 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_tick", 32'(tick_out), 0);
    @(negedge clk) reset_n = 1;
    rd(5'h02, d); chk("rst_period0", d, 99999);
    rd(5'h00, d); chk("rst_status0", d, 0);
    rd(5'h0F, d); chk("rst_snap3", d, 0);
    chk("rst_irq2", 32'(irq), 0);

    // continuous mode, period 9
    wr(5'h02, 9); repeat (2) @(posedge clk);
    mark(); wr(5'h01, 7); t = we;
    repeat (35) @(posedge clk); #1;
    chk("cont_count", 32'(tq[0].size() - base[0]), 3);
    chk("cont_first", 32'(first_tick(0)), 32'(t + 10));
    chk("cont_last", 32'(last_tick(0)), 32'(t + 30));
    chk("cont_irq", 32'(irq), 1);
    rd(5'h00, d); chk("cont_status", d, 3);
    wr(5'h01, 32'h0B);
    wr(5'h00, 0);
    chk("cont_irq_clr", 32'(irq), 0);
    rd(5'h00, d); chk("cont_status_clr", d, 0);

    // one-shot mode on ch1, period 4
    wr(5'h06, 4); repeat (2) @(posedge clk);
    mark(); wr(5'h05, 4); t = we;
    repeat (20) @(posedge clk); #1;
    chk("one_count", 32'(tq[1].size() - base[1]), 1);
    chk("one_first", 32'(first_tick(1)), 32'(t + 5));
    rd(5'h04, d); chk("one_status", d, 1);
    wr(5'h07, 0); rd(5'h07, d); chk("one_snap", d, 4);
    chk("one_irq", 32'(irq), 0);

    // synchronised start of ch0 (period 3) and ch1 (period 7)
    wr(5'h02, 3); wr(5'h06, 7); wr(5'h01, 2); wr(5'h05, 2);
    repeat (2) @(posedge clk);
    mark(); wr(5'h1D, 3); t = we;
    repeat (9) @(posedge clk); #1;
    chk("sync_cnt0", 32'(tq[0].size() - base[0]), 2);
    chk("sync_first0", 32'(first_tick(0)), 32'(t + 4));
    chk("sync_last0", 32'(last_tick(0)), 32'(t + 8));
    chk("sync_cnt1", 32'(tq[1].size() - base[1]), 1);
    chk("sync_first1", 32'(first_tick(1)), 32'(t + 8));
    wr(5'h1E, 3);
    rd(5'h00, d); chk("sync_stop0", d, 1);

    // clear/timeout collision on ch0, period 5
    wr(5'h02, 5); repeat (2) @(posedge clk);
    wr(5'h01, 7); t = we;
    repeat (2) @(posedge clk); wr(5'h00, 0);
    chk("coll_clear_irq", 32'(irq), 0);
    repeat (2) @(posedge clk); wr(5'h00, 0);
    chk("coll_irq", 32'(irq), 1);
    chk("coll_tick", 32'(tick_out[0]), 1);
    rd(5'h00, d); chk("coll_status", d, 3);
    repeat ($urandom_range(1, 12)) @(posedge clk);
    wr(5'h03, 0); c = we - 1 - t;
    rd(5'h03, d); chk("snap_mid", d, 32'(exp_cnt(5, c)));
    wr(5'h02, 12); repeat (1) @(posedge clk);
    rd(5'h00, d); chk("pwr_run", 32'(d[1]), 0);
    wr(5'h03, 0); rd(5'h03, d); chk("pwr_cnt", d, 12);

    // randomized synchronised runs on all channels
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NC; i++) begin
        per[i] = $urandom_range(2, 20);
        wr(5'(i * 4 + 2), per[i]);
        wr(5'(i * 4 + 1), 2);
      end
      repeat (2) @(posedge clk);
      mark(); wr(5'h1D, 32'hF); t = we;
      c = $urandom_range(25, 90);
      repeat (c - 1) @(posedge clk);
      wr(5'h1E, 32'hF);
      for (int i = 0; i < NC; i++) begin
        wr(5'(i * 4 + 3), 0);
        rd(5'(i * 4 + 3), d);
        chk($sformatf("rnd%0d_cnt%0d", r, i), d, 32'(exp_cnt(per[i], c)));
        chk($sformatf("rnd%0d_ticks%0d", r, i), 32'(tq[i].size() - base[i]), 32'(c / (per[i] + 1)));
      end
    end

    // global IRQ_PEND and unmapped addresses
    wr(5'h09, 1);
    rd(5'h1C, d); chk("irq_pend", d, 4);
    chk("irq_ch2", 32'(irq), 1);
    rd(5'h1F, d); chk("unmap_1F", d, 0);
    rd(5'h13, d); chk("unmap_ch4", d, 0);
    wr(5'h12, 55);
    rd(5'h12, d); chk("unmap_wr", d, 0);
    rd(5'h1D, d); chk("start_mask_rd", d, 0);

    // reset while running
    wr(5'h02, 2); repeat (2) @(posedge clk);
    wr(5'h01, 7);
    repeat (6) @(posedge clk);
    rd(5'h00, d); chk("pre_rst_status", d, 3);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_readdata", readdata, 0);
    chk("mid_rst_irq", 32'(irq), 0);
    chk("mid_rst_tick", 32'(tick_out), 0);
    @(negedge clk) reset_n = 1;
    rd(5'h02, d); chk("post_rst_period", d, 99999);
    rd(5'h00, d); chk("post_rst_status", d, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
